// File: rtl/pipeline_pkg.sv
// Shared constants, next-PC select encoding and PC helpers for the fetch stage.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package pipeline_pkg;

   localparam logic [31:0] RST_VEC_DEF = 32'h8000_0000;
   localparam logic [31:0] IRQ_VEC_DEF = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC_DEF = 32'h8000_0008;

   // Next-PC sources, listed from highest to lowest priority
   typedef enum logic [2:0] {
      SEL_EXC  = 3'd0,
      SEL_IRQ  = 3'd1,
      SEL_BR   = 3'd2,
      SEL_JMP  = 3'd3,
      SEL_HOLD = 3'd4,
      SEL_INC  = 3'd5
   } npc_sel_e;

   // Sequential increment never carries into the mode bit
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

   // User code cannot reach kernel space through a branch or jump;
   // kernel code may leave kernel space (e.g. jr back to the user program)
   function automatic logic [31:0] mode_target(input logic kernel, input logic [31:0] tgt);
      return kernel ? tgt : {1'b0, tgt[30:0]};
   endfunction

endpackage

// File: rtl/pipeline_npc_sel.sv
// Combinational next-PC priority mux with squash and return-address controls.
// Latency: zero (pure combinational; the caller registers the selected PC).
// Backpressure: stall holds the PC and bubbles EX unless a redirect outranks it.
module pipeline_npc_sel
   import pipeline_pkg::*;
#(
   parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
   input  logic [31:0] pc,
   input  logic        kernel,
   input  logic        irq_req,
   input  logic        stall,
   input  logic        br_take,
   input  logic [31:0] br_target,
   input  logic        jmp_take,
   input  logic [31:0] jmp_target,
   input  logic        illop,
   input  logic [31:0] ifid_pc4,
   output npc_sel_e    sel,
   output logic [31:0] npc,
   output logic        imem_nop,
   output logic        flush_idex,
   output logic        xadr_we,
   output logic [31:0] xadr
);

   logic irq_ok;

   // An interrupt is taken only in user mode on an otherwise quiet cycle,
   // so no in-flight control transfer is lost behind the vector
   assign irq_ok = irq_req & ~kernel & ~stall & ~br_take & ~jmp_take & ~illop;

   // Fixed-priority source selection
   always_comb begin
      sel = SEL_INC;
      if (illop)         sel = SEL_EXC;
      else if (irq_ok)   sel = SEL_IRQ;
      else if (br_take)  sel = SEL_BR;
      else if (jmp_take) sel = SEL_JMP;
      else if (stall)    sel = SEL_HOLD;
   end

   // Next PC and pipeline squash controls for the selected source
   always_comb begin
      npc        = pc_plus4(pc);
      imem_nop   = 1'b0;
      flush_idex = 1'b0;
      xadr_we    = 1'b0;
      xadr       = 32'h0;
      case (sel)
         SEL_EXC: begin
            npc        = EXC_VEC;
            imem_nop   = 1'b1;
            flush_idex = 1'b1;
            xadr_we    = 1'b1;
            xadr       = ifid_pc4;
         end
         SEL_IRQ: begin
            // Return to the instruction in ID, which never executes
            npc        = IRQ_VEC;
            imem_nop   = 1'b1;
            flush_idex = 1'b1;
            xadr_we    = 1'b1;
            xadr       = ifid_pc4 - 32'd4;
         end
         SEL_BR: begin
            npc        = mode_target(kernel, br_target);
            imem_nop   = 1'b1;
            flush_idex = 1'b1;
         end
         SEL_JMP: begin
            // The jump itself is in ID and proceeds into EX
            npc        = mode_target(kernel, jmp_target);
            imem_nop   = 1'b1;
         end
         SEL_HOLD: begin
            npc        = pc;
            flush_idex = 1'b1;
         end
         default: begin
            npc        = pc_plus4(pc);
         end
      endcase
   end

endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// Fetch-stage PC register, pending-interrupt latch and redirect control.
// Latency: redirect controls combinational in the request cycle; PC updates on the next edge.
// Backpressure: stall holds the PC; reset overrides every input in the same cycle.
module pipeline_fetch_ctrl
   import pipeline_pkg::*;
#(
   parameter int          ADDR_W  = 7,
   parameter logic [31:0] RST_VEC = RST_VEC_DEF,
   parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              br_take,
   input  logic [31:0]       br_target,
   input  logic              jmp_take,
   input  logic [31:0]       jmp_target,
   input  logic              irq,
   input  logic              illop,
   input  logic [31:0]       ifid_pc4,
   output logic [31:0]       pc,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_nop,
   output logic              flush_idex,
   output logic              xadr_we,
   output logic [31:0]       xadr,
   output logic              kernel
);

   logic [31:0] pc_q, pc_d;
   logic        irq_pend_q, irq_pend_d;
   logic        irq_req;
   npc_sel_e    sel;
   logic [31:0] npc;
   logic        nop_raw, flush_raw, xadr_we_raw;
   logic [31:0] xadr_raw;

   assign kernel    = pc_q[31];
   assign pc        = pc_q;
   assign imem_addr = pc_q[ADDR_W+1:2];

   // A fresh request can be serviced in the cycle it arrives
   assign irq_req = irq | irq_pend_q;

   pipeline_npc_sel #(
      .IRQ_VEC (IRQ_VEC),
      .EXC_VEC (EXC_VEC)
   ) u_npc_sel (
      .pc         (pc_q),
      .kernel     (kernel),
      .irq_req    (irq_req),
      .stall      (stall),
      .br_take    (br_take),
      .br_target  (br_target),
      .jmp_take   (jmp_take),
      .jmp_target (jmp_target),
      .illop      (illop),
      .ifid_pc4   (ifid_pc4),
      .sel        (sel),
      .npc        (npc),
      .imem_nop   (nop_raw),
      .flush_idex (flush_raw),
      .xadr_we    (xadr_we_raw),
      .xadr       (xadr_raw)
   );

   // Reset masks any redirect requested in the same cycle
   always_comb begin
      imem_nop   = nop_raw & ~reset;
      flush_idex = flush_raw & ~reset;
      xadr_we    = xadr_we_raw & ~reset;
      xadr       = reset ? 32'h0 : xadr_raw;
   end

   // Next-state for PC and the interrupt latch (held until serviced)
   always_comb begin
      pc_d       = npc;
      irq_pend_d = irq_req & (sel != SEL_IRQ);
   end

   // PC and pending-interrupt registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RST_VEC;
         irq_pend_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         irq_pend_q <= irq_pend_d;
      end
   end

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// Self-checking bench for pipeline_fetch_ctrl: directed scenarios then random traffic.
// Latency: checks combinational outputs mid-cycle and the PC after each edge.
// Backpressure: stall driven directly and at random.
module tb_pipeline_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall, br_take, jmp_take, irq, illop;
   logic [31:0] br_target, jmp_target, ifid_pc4;
   logic [31:0] pc, xadr;
   logic [6:0]  imem_addr;
   logic        imem_nop, flush_idex, xadr_we, kernel;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state and the values it predicts for the current cycle
   logic [31:0] m_pc;
   logic        m_pend;
   logic [31:0] e_npc, e_xadr;
   logic        e_pend, e_nop, e_flush, e_we;

   pipeline_fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_take    (br_take),
      .br_target  (br_target),
      .jmp_take   (jmp_take),
      .jmp_target (jmp_target),
      .irq        (irq),
      .illop      (illop),
      .ifid_pc4   (ifid_pc4),
      .pc         (pc),
      .imem_addr  (imem_addr),
      .imem_nop   (imem_nop),
      .flush_idex (flush_idex),
      .xadr_we    (xadr_we),
      .xadr       (xadr),
      .kernel     (kernel)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      reset = 0; stall = 0; br_take = 0; jmp_take = 0; irq = 0; illop = 0;
      br_target = 0; jmp_target = 0; ifid_pc4 = 0;
   endtask

   // Predict this cycle's outputs and next state from the rules, then compare
   task automatic eval_cmp();
      logic in_kernel, want_irq;
      logic [31:0] tgt;
      #1;
      in_kernel = m_pc[31];
      want_irq  = irq | m_pend;
      e_nop = 0; e_flush = 0; e_we = 0; e_xadr = 0;
      e_pend = want_irq;
      if (reset) begin
         e_npc  = 32'h8000_0000;
         e_pend = 0;
      end else if (illop) begin
         e_npc = 32'h8000_0008; e_we = 1; e_xadr = ifid_pc4; e_nop = 1; e_flush = 1;
      end else if (want_irq && !in_kernel && !stall && !br_take && !jmp_take) begin
         e_npc = 32'h8000_0004; e_we = 1; e_xadr = ifid_pc4 - 4; e_nop = 1; e_flush = 1;
         e_pend = 0;
      end else if (br_take) begin
         tgt   = in_kernel ? br_target : (br_target & 32'h7fff_ffff);
         e_npc = tgt; e_nop = 1; e_flush = 1;
      end else if (jmp_take) begin
         tgt   = in_kernel ? jmp_target : (jmp_target & 32'h7fff_ffff);
         e_npc = tgt; e_nop = 1;
      end else if (stall) begin
         e_npc = m_pc; e_flush = 1;
      end else begin
         e_npc = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7fff_ffff);
      end
      chk("pc",         pc,                      m_pc);
      chk("imem_addr",  {25'd0, imem_addr},      (m_pc >> 2) % 128);
      chk("kernel",     {31'd0, kernel},         {31'd0, m_pc[31]});
      chk("imem_nop",   {31'd0, imem_nop},       {31'd0, e_nop});
      chk("flush_idex", {31'd0, flush_idex},     {31'd0, e_flush});
      chk("xadr_we",    {31'd0, xadr_we},        {31'd0, e_we});
      chk("xadr",       xadr,                    e_xadr);
   endtask

   task automatic tick();
      @(posedge clk);
      m_pc   = e_npc;
      m_pend = e_pend;
      @(negedge clk);
   endtask

   // Kernel-mode jump, used to place the PC anywhere
   task automatic jump_to(input logic [31:0] t);
      idle_inputs();
      jmp_take = 1; jmp_target = t;
      eval_cmp(); tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_pc = 32'h8000_0000; m_pend = 0;
      reset = 0;

      // Free-running fetch after reset
      for (int i = 0; i < 4; i++) begin
         chk("rst_seq_pc",   pc, 32'h8000_0000 + 32'(4 * i));
         chk("rst_seq_addr", {25'd0, imem_addr}, 32'(i));
         eval_cmp(); tick();
      end

      // Interrupt during kernel mode waits until user mode
      irq = 1; eval_cmp();
      chk("kirq_no_we", {31'd0, xadr_we}, 32'd0);
      tick(); irq = 0;
      repeat (3) begin eval_cmp(); tick(); end
      jump_to(32'h0000_0040);
      chk("jr_user_pc", pc, 32'h0000_0040);
      chk("jr_user_k",  {31'd0, kernel}, 32'd0);
      ifid_pc4 = 32'h0000_0044;
      eval_cmp();
      chk("kirq_we",   {31'd0, xadr_we}, 32'd1);
      chk("kirq_xadr", xadr, 32'h0000_0040);
      tick();
      chk("kirq_pc", pc, 32'h8000_0004);

      // Interrupt in user mode
      jump_to(32'h0000_00A0);
      ifid_pc4 = 32'h0000_009C; irq = 1;
      eval_cmp();
      chk("uirq_we",   {31'd0, xadr_we}, 32'd1);
      chk("uirq_xadr", xadr, 32'h0000_0098);
      chk("uirq_nop",  {31'd0, imem_nop}, 32'd1);
      tick(); irq = 0;
      chk("uirq_pc", pc, 32'h8000_0004);

      // Branch beats a same-cycle jump
      br_take = 1; br_target = 32'h0000_00B0; jmp_take = 1; jmp_target = 32'h0000_0200;
      eval_cmp();
      chk("br_flush", {31'd0, flush_idex}, 32'd1);
      tick(); idle_inputs();
      chk("br_pc", pc, 32'h0000_00B0);

      // User jump cannot enter kernel space
      jmp_take = 1; jmp_target = 32'h8000_0010;
      eval_cmp(); tick(); idle_inputs();
      chk("ujmp_pc", pc, 32'h0000_0010);
      chk("ujmp_k",  {31'd0, kernel}, 32'd0);

      // Two-cycle stall holds the PC and bubbles EX
      jmp_take = 1; jmp_target = 32'h0000_0020;
      eval_cmp(); tick(); idle_inputs();
      for (int i = 0; i < 2; i++) begin
         stall = 1;
         eval_cmp();
         chk("stall_flush", {31'd0, flush_idex}, 32'd1);
         tick();
         chk("stall_pc", pc, 32'h0000_0020);
      end
      idle_inputs();

      // Reset wins over an illegal opcode
      illop = 1; reset = 1; ifid_pc4 = 32'h0000_0024;
      eval_cmp();
      chk("rst_illop_we", {31'd0, xadr_we}, 32'd0);
      tick(); idle_inputs();
      chk("rst_illop_pc", pc, 32'h8000_0000);
      eval_cmp();
      chk("rst_illop_we2", {31'd0, xadr_we}, 32'd0);
      tick();

      // Random traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 99) == 0);
         illop      = ($urandom_range(0, 15) == 0);
         br_take    = ($urandom_range(0, 7) == 0);
         jmp_take   = ($urandom_range(0, 7) == 0);
         stall      = ($urandom_range(0, 5) == 0);
         irq        = ($urandom_range(0, 9) == 0);
         br_target  = $urandom;
         jmp_target = $urandom;
         ifid_pc4   = $urandom;
         eval_cmp(); tick();
      end
      idle_inputs();
      eval_cmp(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_fetch_ctrl.md
PIPELINE_FETCH_CTRL -- requirements
Module: pipeline_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, instruction-memory word-address width.
REQ-002 SHALL have parameter RST_VEC, default 32'h8000_0000, reset vector.
REQ-003 SHALL have parameter IRQ_VEC, default 32'h8000_0004, interrupt vector.
REQ-004 SHALL have parameter EXC_VEC, default 32'h8000_0008, illegal-opcode vector.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port stall  in  1  load-use hazard from ID; hold PC.
REQ-008 SHALL have port br_take  in  1  branch resolved taken in EX.
REQ-009 SHALL have port br_target  in  32  branch target.
REQ-010 SHALL have port jmp_take  in  1  j/jal/jr decoded in ID.
REQ-011 SHALL have port jmp_target  in  32  jump target.
REQ-012 SHALL have port irq  in  1  timer interrupt request, level.
REQ-013 SHALL have port illop  in  1  illegal opcode in ID.
REQ-014 SHALL have port ifid_pc4  in  32  PC+4 of the instruction currently in ID.
REQ-015 SHALL have port pc  out  32  current fetch PC.
REQ-016 SHALL have port imem_addr  out  ADDR_W  pc[ADDR_W+1:2] to instruction memory.
REQ-017 SHALL have port imem_nop  out  1  squash fetched word into IF/ID.
REQ-018 SHALL have port flush_idex  out  1  squash instruction entering EX.
REQ-019 SHALL have port xadr_we  out  1  write $26 (xp) this cycle.
REQ-020 SHALL have port xadr  out  32  return address for $26.
REQ-021 SHALL have port kernel  out  1  supervisor mode, equals pc[31].

Function
REQ-022 SHALL select next PC by priority: illop > serviceable irq > br_take > jmp_take > stall (hold) > PC+4.
REQ-023 SHALL compute PC+4 on bits [30:0] only, preserving pc[31].
REQ-024 SHALL, in user mode (kernel=0), force bit 31 of br/jmp targets to 0; in kernel mode pass targets unmodified (jr to user address exits kernel).
REQ-025 SHALL latch irq into irq_pend register; irq_pend clears only when serviced or on reset.
REQ-026 SHALL treat irq_pend as serviceable only when kernel=0, stall=0, br_take=0, jmp_take=0, illop=0.
REQ-027 SHALL on irq service: pc<=IRQ_VEC, xadr_we=1, xadr=ifid_pc4-4, imem_nop=1, flush_idex=1.
REQ-028 SHALL on illop (any mode): pc<=EXC_VEC, xadr_we=1, xadr=ifid_pc4, imem_nop=1, flush_idex=1.
REQ-029 SHALL on br_take: pc<=target, imem_nop=1, flush_idex=1; jmp_take in same cycle ignored.
REQ-030 SHALL on jmp_take (no br_take): pc<=target, imem_nop=1, flush_idex=0.
REQ-031 SHALL on stall alone: hold pc, imem_nop=0, flush_idex=1 (bubble into EX).
REQ-032 SHALL drive imem_nop, flush_idex, xadr_we, xadr combinationally in the redirect cycle; redirect takes effect on the next edge (one-cycle latency).
REQ-033 SHALL wrap imem_addr modulo 2^ADDR_W; no range check.
REQ-034 SHALL keep irq arriving while kernel=1 pending until kernel returns to 0.

Reset
REQ-035 SHALL on reset set pc=RST_VEC, irq_pend=0; outputs then: kernel=1, imem_nop=0, flush_idex=0, xadr_we=0, xadr=0.
REQ-036 SHALL let reset override all inputs in the same cycle, including mid-redirect.

Structure
REQ-037 SHALL place vector constants and the next-PC select enum (SEL_EXC, SEL_IRQ, SEL_BR, SEL_JMP, SEL_HOLD, SEL_INC) in shared package pipeline_pkg.
REQ-038 SHALL contain one natural sub-module, pipeline_npc_sel (combinational priority mux); PC and irq_pend registers stay in the top.

Verification
REQ-039 SHALL check: reset then 3 free cycles -> pc 8000_0000, 8000_0004, 8000_0008, 8000_000C; imem_addr 0,1,2,3.
REQ-040 SHALL check: user pc=0000_00A0, ifid_pc4=0000_009C, irq=1 one cycle -> next pc=8000_0004, xadr=0000_0098, xadr_we=1, imem_nop=1.
REQ-041 SHALL check: br_take=1 target 0000_00B0 with jmp_take=1 target 0000_0200 same cycle -> pc=0000_00B0, flush_idex=1.
REQ-042 SHALL check: user jmp_target 8000_0010 -> pc=0000_0010, kernel stays 0.
REQ-043 SHALL check: irq=1 while kernel=1, then jr to 0000_0040 -> irq serviced the first eligible cycle after, xadr=ifid_pc4-4.
REQ-044 SHALL check: stall=1 for 2 cycles at pc=0000_0020 -> pc holds, flush_idex=1 both cycles; reset asserted during illop -> pc=8000_0000, xadr_we=0.
